// File: rtl/hpc2_and_pipe.sv
// hpc2_and_pipe: HPC2 masked AND gadget over NSHARES Boolean shares.
// Three register stages with valid/ready flow control.
module hpc2_and_pipe #(
    parameter int NSHARES = 3,
    parameter int WIDTH   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NSHARES*WIDTH-1:0]               a,
    input  logic [NSHARES*WIDTH-1:0]               b,
    input  logic [NSHARES*(NSHARES-1)/2*WIDTH-1:0] r,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NSHARES*WIDTH-1:0]               c
);
    localparam int NRAND = NSHARES * (NSHARES - 1) / 2;

    typedef logic [WIDTH-1:0] word_t;

    function automatic int ridx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NSHARES - lo * (lo + 1) / 2 + (hi - lo - 1);
    endfunction

    logic  enable;
    logic  v1;
    logic  v2;
    word_t rw  [NRAND];
    word_t a1  [NSHARES];
    word_t na1 [NSHARES];
    // Diagonal of br1 carries b_i; diagonal of r1 is zero so w_ii vanishes.
    word_t br1 [NSHARES][NSHARES];
    word_t r1  [NSHARES][NSHARES];
    // Diagonal of vq carries u_ii = a_i & b_i.
    word_t vq  [NSHARES][NSHARES];
    word_t wq  [NSHARES][NSHARES];
    word_t s3  [NSHARES];

    assign enable   = ~out_valid | out_ready;
    assign in_ready = enable;

    always_comb begin
        for (int k = 0; k < NRAND; k++) begin
            rw[k] = r[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        for (int i = 0; i < NSHARES; i++) begin
            s3[i] = '0;
            for (int j = 0; j < NSHARES; j++) begin
                s3[i] = s3[i] ^ vq[i][j] ^ wq[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            c         <= '0;
            for (int i = 0; i < NSHARES; i++) begin
                a1[i]  <= '0;
                na1[i] <= '0;
                for (int j = 0; j < NSHARES; j++) begin
                    br1[i][j] <= '0;
                    r1[i][j]  <= '0;
                    vq[i][j]  <= '0;
                    wq[i][j]  <= '0;
                end
            end
        end else if (enable) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            for (int i = 0; i < NSHARES; i++) begin
                a1[i]  <= a[i*WIDTH +: WIDTH];
                na1[i] <= ~a[i*WIDTH +: WIDTH];
                for (int j = 0; j < NSHARES; j++) begin
                    if (i == j) begin
                        r1[i][j]  <= '0;
                        br1[i][j] <= b[i*WIDTH +: WIDTH];
                    end else begin
                        r1[i][j]  <= rw[ridx(i, j)];
                        br1[i][j] <= b[j*WIDTH +: WIDTH] ^ rw[ridx(i, j)];
                    end
                    vq[i][j] <= a1[i] & br1[i][j];
                    wq[i][j] <= na1[i] & r1[i][j];
                end
                c[i*WIDTH +: WIDTH] <= s3[i];
            end
        end
    end

endmodule
